bg_trim_avg: RTL and testbench

Downstream consumer of the bandgap SAR trim controller. Detects each result-valid pulse from the controller, captures the 16-bit trim word {coarse, fine}, averages 2^AVG_LOG2 consecutive results and presents the averaged trim word on a valid/ready handshake to the trim register/readout logic. Optionally tracks result stability and flags lock.

---
 rtl/bg_trim_avg.sv | 200 ++++++++++++++++++++
 tb/tb_bg_trim_avg.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/bg_trim_avg.sv
// bg_trim_avg: captures one {coarse,fine} trim word per rising edge of the
// SAR controller's result-valid level. It averages 2^AVG_LOG2 consecutive
// words and offers the averaged word on a valid/ready output.
// Optional feature macro: BG_TRIM_LOCK_EN. When it is defined, the block
// tracks how stable consecutive averages are and drives 'locked'. When it is
// undefined, 'locked' is tied to 0.
//
// Output handshake: trim_code is offered while trim_valid=1. It transfers on
// any clock edge where trim_valid and trim_ready are both 1. While trim_valid=1
// and trim_ready=0, trim_code and trim_valid hold steady.
module bg_trim_avg #(
   parameter int AVG_LOG2   = 2,
   parameter int LOCK_TOL   = 2,
   parameter int LOCK_COUNT = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pwrup,
   input  logic        valid_in,
   input  logic [7:0]  coarse_in,
   input  logic [7:0]  fine_in,
   input  logic        trim_ready,
   output logic [15:0] trim_code,
   output logic        trim_valid,
   output logic        locked,
   output logic        overrun,
   output logic [3:0]  sample_cnt,
   output logic [1:0]  dbg_state_o
);

   localparam int         ACC_W     = 16 + AVG_LOG2;
   localparam logic [4:0] N_SAMPLES = 5'(1 << AVG_LOG2);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_PRESENT = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic               valid_d_q;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [3:0]         cnt_q, cnt_d;
   logic [15:0]        code_q, code_d;
   logic               tvalid_q, tvalid_d;
   logic               overrun_q, overrun_d;

   logic [15:0]        sample;
   logic               capture;
   logic [ACC_W-1:0]   acc_sum;
   logic [4:0]         cnt_inc;
   logic [15:0]        avg;
   logic               new_avg;

   assign sample  = {coarse_in, fine_in};
   // A capture happens only on the rising edge of valid_in, so each pulse is
   // captured once no matter how long it stays high.
   assign capture = valid_in & ~valid_d_q;
   assign acc_sum = acc_q + ACC_W'(sample);
   assign cnt_inc = {1'b0, cnt_q} + 5'd1;
   assign avg     = 16'(acc_sum >> AVG_LOG2);

   // State register and the datapath registers of the averager
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         valid_d_q <= 1'b0;
         acc_q     <= '0;
         cnt_q     <= '0;
         code_q    <= '0;
         tvalid_q  <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         valid_d_q <= valid_in;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         code_q    <= code_d;
         tvalid_q  <= tvalid_d;
         overrun_q <= overrun_d;
      end
   end

   // Next-state logic. Power-down flushes the window but keeps the last
   // trim_code and the sticky overrun flag.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      code_d    = code_q;
      tvalid_d  = tvalid_q;
      overrun_d = overrun_q;
      new_avg   = 1'b0;
      if (!pwrup) begin
         state_d  = ST_IDLE;
         acc_d    = '0;
         cnt_d    = '0;
         tvalid_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               acc_d   = '0;
               cnt_d   = '0;
               state_d = ST_COLLECT;
            end
            ST_COLLECT: begin
               if (capture) begin
                  if (cnt_inc == N_SAMPLES) begin
                     code_d   = avg;
                     tvalid_d = 1'b1;
                     acc_d    = '0;
                     cnt_d    = '0;
                     state_d  = ST_PRESENT;
                     new_avg  = 1'b1;
                  end else begin
                     acc_d = acc_sum;
                     cnt_d = cnt_inc[3:0];
                  end
               end
            end
            ST_PRESENT: begin
               // No capture is possible while an average waits. This also
               // applies in the cycle where the average is accepted.
               if (capture) begin
                  overrun_d = 1'b1;
               end
               if (trim_ready) begin
                  tvalid_d = 1'b0;
                  state_d  = ST_COLLECT;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

`ifdef BG_TRIM_LOCK_EN
   localparam logic [15:0] TOL_W = 16'(LOCK_TOL);
   localparam logic [3:0]  LC_W  = 4'(LOCK_COUNT);

   logic [15:0] prev_q, prev_d;
   logic        have_prev_q, have_prev_d;
   logic [3:0]  streak_q, streak_d;
   logic        locked_q, locked_d;
   logic [15:0] diff;

   assign diff = (avg >= prev_q) ? (avg - prev_q) : (prev_q - avg);

   // Lock tracking registers
   always_ff @(posedge clk) begin
      if (reset) begin
         prev_q      <= '0;
         have_prev_q <= 1'b0;
         streak_q    <= '0;
         locked_q    <= 1'b0;
      end else begin
         prev_q      <= prev_d;
         have_prev_q <= have_prev_d;
         streak_q    <= streak_d;
         locked_q    <= locked_d;
      end
   end

   // The streak counts consecutive close averages and saturates at LOCK_COUNT.
   // The first average after a flush has no predecessor.
   always_comb begin
      prev_d      = prev_q;
      have_prev_d = have_prev_q;
      streak_d    = streak_q;
      locked_d    = locked_q;
      if (!pwrup) begin
         have_prev_d = 1'b0;
         streak_d    = '0;
         locked_d    = 1'b0;
      end else if (new_avg) begin
         if (have_prev_q && (diff <= TOL_W)) begin
            streak_d = (streak_q >= LC_W) ? LC_W : streak_q + 4'd1;
         end else begin
            streak_d = '0;
         end
         prev_d      = avg;
         have_prev_d = 1'b1;
         locked_d    = (streak_d == LC_W);
      end
   end

   assign locked = locked_q;
`else
   logic unused_new_avg;
   assign unused_new_avg = new_avg;
   assign locked         = 1'b0;
`endif

   assign trim_code   = code_q;
   assign trim_valid  = tvalid_q;
   assign overrun     = overrun_q;
   assign sample_cnt  = cnt_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bg_trim_avg.sv
// Directed bench for bg_trim_avg. Expected values are computed by hand.
// The expected 'locked' values depend on whether BG_TRIM_LOCK_EN is defined.
module tb_bg_trim_avg;

   logic        clk;
   logic        reset;
   logic        pwrup;
   logic        valid_in;
   logic [7:0]  coarse_in;
   logic [7:0]  fine_in;
   logic        trim_ready;
   logic [15:0] trim_code;
   logic        trim_valid;
   logic        locked;
   logic        overrun;
   logic [3:0]  sample_cnt;
   logic [1:0]  dbg_state_o;

   int n_cmp = 0;
   int n_err = 0;

   bg_trim_avg dut (
      .clk        (clk),
      .reset      (reset),
      .pwrup      (pwrup),
      .valid_in   (valid_in),
      .coarse_in  (coarse_in),
      .fine_in    (fine_in),
      .trim_ready (trim_ready),
      .trim_code  (trim_code),
      .trim_valid (trim_valid),
      .locked     (locked),
      .overrun    (overrun),
      .sample_cnt (sample_cnt),
      .dbg_state_o(dbg_state_o)
   );

   // 10 MHz clock
   initial clk = 1'b0;
   always #50 clk = ~clk;

`ifdef BG_TRIM_LOCK_EN
   localparam logic LK = 1'b1;
`else
   localparam logic LK = 1'b0;
`endif

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic pulse(input logic [15:0] w, input int hi);
      valid_in  = 1'b1;
      coarse_in = w[15:8];
      fine_in   = w[7:0];
      repeat (hi) tick();
      valid_in = 1'b0;
      tick();
   endtask

   // Three full pulses, then raise valid for the fourth word and stop just
   // after its capture edge, so that the caller can check the result.
   task automatic window(input logic [15:0] w0, input logic [15:0] w1,
                         input logic [15:0] w2, input logic [15:0] w3);
      pulse(w0, 2);
      pulse(w1, 2);
      pulse(w2, 2);
      valid_in  = 1'b1;
      coarse_in = w3[15:8];
      fine_in   = w3[7:0];
      tick();
   endtask

   task automatic end_pulse();
      tick();
      valid_in = 1'b0;
      tick();
   endtask

   initial begin
      reset      = 1'b1;
      pwrup      = 1'b0;
      valid_in   = 1'b0;
      coarse_in  = 8'h00;
      fine_in    = 8'h00;
      trim_ready = 1'b1;
      tick();
      chk("rst_code",    32'(trim_code),   32'h0);
      chk("rst_valid",   32'(trim_valid),  32'h0);
      chk("rst_locked",  32'(locked),      32'h0);
      chk("rst_overrun", 32'(overrun),     32'h0);
      chk("rst_cnt",     32'(sample_cnt),  32'h0);
      chk("rst_state",   32'(dbg_state_o), 32'h0);
      tick();
      reset = 1'b0;

      pwrup = 1'b1;
      tick();
      chk("pwrup_collect", 32'(dbg_state_o), 32'h1);

      // Basic average: 0x8040..0x8046 gives 0x8043. Each pulse is 3 cycles.
      pulse(16'h8040, 3);
      pulse(16'h8042, 3);
      chk("cnt_after2", 32'(sample_cnt), 32'h2);
      pulse(16'h8044, 3);
      valid_in  = 1'b1;
      coarse_in = 8'h80;
      fine_in   = 8'h46;
      tick();
      chk("avg1_valid",  32'(trim_valid),  32'h1);
      chk("avg1_code",   32'(trim_code),   32'h8043);
      chk("avg1_cnt",    32'(sample_cnt),  32'h0);
      chk("avg1_state",  32'(dbg_state_o), 32'h2);
      chk("avg1_locked", 32'(locked),      32'h0);
      tick();
      chk("avg1_accept", 32'(trim_valid),  32'h0);
      chk("avg1_back",   32'(dbg_state_o), 32'h1);
      tick();
      valid_in = 1'b0;
      tick();
      chk("avg1_no_ovr", 32'(overrun), 32'h0);

      // A long pulse is captured only once.
      valid_in  = 1'b1;
      coarse_in = 8'h12;
      fine_in   = 8'h34;
      repeat (10) tick();
      chk("long_pulse_cnt", 32'(sample_cnt), 32'h1);
      valid_in = 1'b0;
      tick();
      pulse(16'h2222, 3);
      chk("mid_cnt2", 32'(sample_cnt), 32'h2);

      // Power-down in the middle of a window flushes it.
      pwrup = 1'b0;
      tick();
      chk("pd_cnt",    32'(sample_cnt),  32'h0);
      chk("pd_state",  32'(dbg_state_o), 32'h0);
      chk("pd_locked", 32'(locked),      32'h0);
      chk("pd_code",   32'(trim_code),   32'h8043);
      pulse(16'hFFFF, 2);
      chk("pd_ignore", 32'(sample_cnt), 32'h0);
      chk("pd_no_ovr", 32'(overrun),    32'h0);
      pwrup = 1'b1;
      tick();

      // Lock sequence 0x8043, 0x8044, 0x8042, 0x8043, then 0x8050.
      // The first window also checks that only fresh samples are used.
      window(16'h8040, 16'h8042, 16'h8044, 16'h8046);
      chk("w1_valid",  32'(trim_valid), 32'h1);
      chk("w1_code",   32'(trim_code),  32'h8043);
      chk("w1_locked", 32'(locked),     32'h0);
      end_pulse();
      window(16'h8044, 16'h8044, 16'h8044, 16'h8044);
      chk("w2_code",   32'(trim_code),  32'h8044);
      chk("w2_locked", 32'(locked),     32'h0);
      end_pulse();
      window(16'h8042, 16'h8042, 16'h8042, 16'h8042);
      chk("w3_code",   32'(trim_code),  32'h8042);
      chk("w3_locked", 32'(locked),     32'h0);
      end_pulse();
      // Sum of offsets 0+1+3+6 = 10, and 10>>2 = 2 after truncation.
      window(16'h8041, 16'h8042, 16'h8044, 16'h8047);
      chk("w4_code",   32'(trim_code),  32'h8043);
      chk("w4_locked", 32'(locked),     32'(LK));
      end_pulse();
      chk("w4_hold_locked", 32'(locked), 32'(LK));
      window(16'h8050, 16'h8050, 16'h8050, 16'h8050);
      chk("w5_code",   32'(trim_code),  32'h8050);
      chk("w5_locked", 32'(locked),     32'h0);
      end_pulse();

      // Backpressure: a capture while an average waits is dropped.
      trim_ready = 1'b0;
      window(16'h0100, 16'h0100, 16'h0100, 16'h0100);
      chk("bp_valid", 32'(trim_valid), 32'h1);
      chk("bp_code",  32'(trim_code),  32'h0100);
      end_pulse();
      repeat (3) tick();
      chk("bp_hold_valid", 32'(trim_valid), 32'h1);
      chk("bp_hold_code",  32'(trim_code),  32'h0100);
      chk("bp_no_ovr_yet", 32'(overrun),    32'h0);
      pulse(16'h0F00, 2);
      chk("ovr_set",   32'(overrun),    32'h1);
      chk("ovr_code",  32'(trim_code),  32'h0100);
      chk("ovr_cnt",   32'(sample_cnt), 32'h0);
      chk("ovr_valid", 32'(trim_valid), 32'h1);
      trim_ready = 1'b1;
      tick();
      chk("bp_release", 32'(trim_valid),  32'h0);
      chk("bp_state",   32'(dbg_state_o), 32'h1);
      chk("ovr_sticky", 32'(overrun),     32'h1);

      // Only reset clears overrun.
      reset = 1'b1;
      tick();
      chk("rst2_overrun", 32'(overrun),   32'h0);
      chk("rst2_code",    32'(trim_code), 32'h0);
      reset = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
